// File: rtl/cereal_pkg.sv
// Shared types and constants for the cereal serializer arbiter.
package cereal_pkg;

  localparam int BYTE_W = 8;
  localparam int ID_W   = 3;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_START_CYCLES = 300;
  localparam int DEF_FRAME_CYCLES = 52080;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cereal_arbiter_rr_pick.sv
// Round-robin winner search: first set request bit strictly after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import cereal_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // Pad to 8 bits so a 3-bit index always lands inside the vector.
  logic [7:0] req_pad;
  assign req_pad = 8'(req);

  // Scan ptr+1, ptr+2, ... wrapping; the first request found wins.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!valid && req_pad[idx[2:0]]) begin
        winner = idx[2:0];
        valid  = 1'b1;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/cereal_arbiter.sv
// cereal_arbiter: shares one cereal serializer between NUM_REQ byte producers.
// Round-robin grant, byte latched at grant, ser_start held START_CYCLES,
// then a hold-off until FRAME_CYCLES after the start rise, then a one-cycle ack.
// Optional build macro: CEREAL_ARB_PRIO0_EN -- requester 0 becomes fixed highest
// priority (wins without moving rr_ptr); the rest round-robin among themselves.
module cereal_arbiter
  import cereal_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [BYTE_W-1:0]         ser_data,
  output logic                      ser_start
);

  localparam int                CNT_W      = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ID_W-1:0]   PTR_INIT   = ID_W'(NUM_REQ - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]  rr_req;
  logic [ID_W-1:0]     rr_winner;
  logic                rr_valid;
  logic [ID_W-1:0]     pick;
  logic                pick_valid;
  logic                ptr_update;
  logic [BYTE_W-1:0]   pick_byte;

  // Requests that take part in the round-robin search.
  always_comb begin
    rr_req = req;
`ifdef CEREAL_ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (rr_req),
    .ptr    (rr_ptr),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Final winner; a fixed-priority win by requester 0 leaves rr_ptr alone.
  always_comb begin
    pick       = rr_winner;
    pick_valid = rr_valid;
    ptr_update = rr_valid;
`ifdef CEREAL_ARB_PRIO0_EN
    if (req[0]) begin
      pick       = '0;
      pick_valid = 1'b1;
      ptr_update = 1'b0;
    end else begin
      pick       = rr_winner;
    end
`endif
  end

  // Byte slot belonging to the winner.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) begin
        pick_byte = req_data[BYTE_W*i +: BYTE_W];
      end else begin
        pick_byte = pick_byte;
      end
    end
  end

  // Grant/frame FSM with the shared frame counter; all outputs registered.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= PTR_INIT;
      ack       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      ser_data  <= '0;
      ser_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            ser_data <= pick_byte;
            grant_id <= pick;
            if (ptr_update) begin
              rr_ptr <= pick;
            end
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Data has had one cycle to settle; raise the start strobe.
          cnt       <= '0;
          ser_start <= 1'b1;
          state     <= START;
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (cnt == START_LAST) begin
            ser_start <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == FRAME_LAST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              ack[i] <= (grant_id == ID_W'(i));
            end
            state <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack       <= '0;
          busy      <= 1'b0;
          ser_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cereal_arbiter.sv
// Directed bench for cereal_arbiter (NUM_REQ=4, START_CYCLES=4, FRAME_CYCLES=20).
// Frame timeline after the edge that grants (k=0): LOAD at k=0, ser_start high
// k=1..4, ack at k=21, IDLE again at k=22. The CEREAL_ARB_PRIO0_EN section runs
// only when that macro is defined.
module tb_cereal_arbiter;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        busy;
  logic [7:0]  ser_data;
  logic        ser_start;

  int errors = 0;
  int checks = 0;

  cereal_arbiter #(
    .NUM_REQ      (4),
    .START_CYCLES (4),
    .FRAME_CYCLES (20)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .ser_data  (ser_data),
    .ser_start (ser_start)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge sysclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {26'd0, busy, ser_start, ack}, 32'd0);
    check({tag, "_dat"}, {21'd0, grant_id, ser_data}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cyc();
    check_reset_vals("rst");
    reset = 1'b0;
  endtask

  // One full frame; req/req_data may be changed at chosen cycles.
  task automatic frame(input string tag, input logic [2:0] id, input logic [7:0] byt,
                       input int drop_k, input logic [3:0] drop_val,
                       input int poke_k, input logic [31:0] poke_val);
    logic [5:0] exp_ctl;
    for (int k = 0; k <= 22; k++) begin
      next_cyc();
      exp_ctl[5]   = (k <= 21);
      exp_ctl[4]   = (k >= 1 && k <= 4);
      exp_ctl[3:0] = (k == 21) ? (4'b0001 << id) : 4'b0000;
      check($sformatf("%s_ctl_k%0d", tag, k), {26'd0, busy, ser_start, ack}, {26'd0, exp_ctl});
      check($sformatf("%s_dat_k%0d", tag, k), {21'd0, grant_id, ser_data}, {21'd0, id, byt});
      if (k == drop_k) req = drop_val;
      if (k == poke_k) req_data = poke_val;
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0000_0000;
    next_cyc();
    next_cyc();
    check_reset_vals("init");
    reset = 1'b0;
    next_cyc();

    // 1: single requester 2
    req      = 4'b0100;
    req_data = 32'h005A_0000;
    frame("t1", 3'd2, 8'h5A, 21, 4'b0000, -1, 32'd0);

    // 2: all requesting, fresh rr_ptr -> 0,1,2,3,0
    do_reset();
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    frame("t2a", 3'd0, 8'h11, -1, 4'b0000, -1, 32'd0);
    frame("t2b", 3'd1, 8'h22, -1, 4'b0000, -1, 32'd0);
    frame("t2c", 3'd2, 8'h33, -1, 4'b0000, -1, 32'd0);
    frame("t2d", 3'd3, 8'h44, -1, 4'b0000, -1, 32'd0);
    frame("t2e", 3'd0, 8'h11, -1, 4'b0000, -1, 32'd0);
    req = 4'b0000;

    // 3: requester 1 drops req right after grant
    req = 4'b0010;
    frame("t3", 3'd1, 8'h22, 0, 4'b0000, -1, 32'd0);
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      check($sformatf("t3_idle_k%0d", k), {31'd0, busy}, 32'd0);
    end

    // 6: slot rewritten during WAIT; byte latched, new byte on next grant
    req = 4'b1000;
    frame("t6a", 3'd3, 8'h44, -1, 4'b0000, 10, 32'hA5A5_A5A5);
    frame("t6b", 3'd3, 8'hA5, 21, 4'b0000, -1, 32'd0);

    // 4: async reset during START
    req = 4'b0100;
    next_cyc();
    next_cyc();
    check("t4_in_start", {31'd0, ser_start}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("t4_async");
    next_cyc();
    check_reset_vals("t4_held");
    reset    = 1'b0;
    req      = 4'b0001;
    req_data = 32'hA5A5_A5C3;
    frame("t4", 3'd0, 8'hC3, 21, 4'b0000, -1, 32'd0);

`ifdef CEREAL_ARB_PRIO0_EN
    // 5: fixed priority for requester 0
    do_reset();
    req      = 4'b1110;
    req_data = 32'h4433_2211;
    frame("t5a", 3'd1, 8'h22, 10, 4'b1111, -1, 32'd0);
    req = 4'b1101;
    frame("t5b", 3'd0, 8'h11, 0, 4'b1100, -1, 32'd0);
    frame("t5c", 3'd2, 8'h33, 21, 4'b0000, -1, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
